// File: rtl/rate_switch_ctrl.sv
// Rate-change sequencer for the divided-clock generator: applies a new select while holding
// the divider in reset, then watches the fed-back divided clock for lock and timeouts.
module rate_switch_ctrl #(
  parameter int unsigned HOLD_CYCLES  = 4,
  parameter int unsigned SETTLE_EDGES = 2,
  parameter int unsigned TIMEOUT      = 1_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  input  logic [1:0] req_div,
  output logic       req_ready,
  output logic [1:0] div,
  output logic       div_reset,
  input  logic       div_clk,
  output logic       locked,
  output logic       done_pulse,
  output logic       err_timeout
);

  localparam int unsigned     TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [3:0]      EDGE_LAST = 4'(SETTLE_EDGES - 1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    SETTLE = 2'b10
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      div_nxt;
  logic            div_reset_nxt, locked_nxt, done_nxt, err_nxt;
  logic [7:0]      hold_cnt, hold_nxt;
  logic [3:0]      edge_cnt, edge_nxt, edge_inc;
  logic [TO_W-1:0] to_cnt, to_nxt, to_inc;
  logic            div_clk_q, rise, accept;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign rise      = div_clk & ~div_clk_q;

  // Counters saturate instead of wrapping so a stuck count can never re-arm a compare.
  assign to_inc   = (to_cnt == '1) ? to_cnt : to_cnt + TO_W'(1);
  assign edge_inc = (edge_cnt == '1) ? edge_cnt : edge_cnt + 4'd1;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt     = state;
    div_nxt       = div;
    div_reset_nxt = div_reset;
    locked_nxt    = locked;
    done_nxt      = 1'b0;
    err_nxt       = err_timeout;
    hold_nxt      = hold_cnt;
    edge_nxt      = edge_cnt;
    to_nxt        = to_cnt;

    case (state)
      IDLE: begin
        if (accept) begin
          div_nxt       = req_div;
          div_reset_nxt = 1'b1;
          locked_nxt    = 1'b0;
          err_nxt       = 1'b0;
          hold_nxt      = '0;
          edge_nxt      = '0;
          to_nxt        = '0;
          state_nxt     = HOLD;
        end else if (locked) begin
          // Watchdog: a locked divider must keep producing rising edges.
          if (rise) begin
            to_nxt = '0;
          end else if (to_cnt >= TO_LAST) begin
            locked_nxt = 1'b0;
            err_nxt    = 1'b1;
          end else begin
            to_nxt = to_inc;
          end
        end
      end

      HOLD: begin
        if (hold_cnt >= HOLD_LAST) begin
          div_reset_nxt = 1'b0;
          state_nxt     = SETTLE;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end

      SETTLE: begin
        to_nxt = to_inc;
        if (rise) edge_nxt = edge_inc;
        // Lock is checked first so it wins a tie with the timeout.
        if (rise && (edge_cnt >= EDGE_LAST)) begin
          locked_nxt = 1'b1;
          done_nxt   = 1'b1;
          to_nxt     = '0;
          state_nxt  = IDLE;
        end else if (to_cnt >= TO_LAST) begin
          locked_nxt = 1'b0;
          err_nxt    = 1'b1;
          state_nxt  = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge, so it only takes effect at the next rising clk.
    if (!reset_n) begin
      state       <= IDLE;
      div         <= 2'b00;
      div_reset   <= 1'b1;
      locked      <= 1'b0;
      done_pulse  <= 1'b0;
      err_timeout <= 1'b0;
      hold_cnt    <= '0;
      edge_cnt    <= '0;
      to_cnt      <= '0;
      div_clk_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the pre-edge values.
      state       <= state_nxt;
      div         <= div_nxt;
      div_reset   <= div_reset_nxt;
      locked      <= locked_nxt;
      done_pulse  <= done_nxt;
      err_timeout <= err_nxt;
      hold_cnt    <= hold_nxt;
      edge_cnt    <= edge_nxt;
      to_cnt      <= to_nxt;
      div_clk_q   <= div_reset ? 1'b0 : div_clk;
    end
  end

endmodule

// File: tb/tb_rate_switch_ctrl.sv
// Self-checking bench for rate_switch_ctrl with a behavioural divider model driving div_clk.
module tb_rate_switch_ctrl;

  localparam int HOLD  = 4;
  localparam int EDGES = 2;
  localparam int TMO   = 10000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_div = 2'b00;
  logic       req_ready, div_reset, locked, done_pulse, err_timeout;
  logic [1:0] div;
  logic       dclk = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  rate_switch_ctrl #(
    .HOLD_CYCLES (HOLD),
    .SETTLE_EDGES(EDGES),
    .TIMEOUT     (TMO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_div    (req_div),
    .req_ready  (req_ready),
    .div        (div),
    .div_reset  (div_reset),
    .div_clk    (dclk),
    .locked     (locked),
    .done_pulse (done_pulse),
    .err_timeout(err_timeout)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: div_clk toggles every N cycles once div_reset is released.
  typedef enum logic [1:0] {DIV_RUN, DIV_LOW, DIV_FREEZE} div_mode_t;
  div_mode_t mode = DIV_RUN;
  int        dcnt = 0;

  function automatic int half_period(input logic [1:0] sel);
    case (sel)
      2'b00:   return 250000;
      2'b01:   return 25000;
      2'b10:   return 2500;
      default: return 250;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mode == DIV_LOW || div_reset !== 1'b0) begin
      dcnt <= 0;
      dclk <= 1'b0;
    end else if (mode == DIV_FREEZE) begin
      dcnt <= dcnt;
    end else if (dcnt >= half_period(div) - 1) begin
      dcnt <= 0;
      dclk <= ~dclk;
    end else begin
      dcnt <= dcnt + 1;
    end
  end

  int   last_rise = 0;
  logic prev_dclk = 1'b0;
  always @(negedge clk) begin
    if (dclk && !prev_dclk) last_rise = cyc;
    prev_dclk = dclk;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: bench did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

  // Holds req_valid until the DUT is ready; returns with t_acc = last cycle before the accept edge.
  task automatic request(input logic [1:0] sel, input string nm, output int t_acc);
    t_acc     = -1;
    req_valid = 1'b1;
    req_div   = sel;
    for (int k = 0; k < 2 * TMO; k++) begin
      if (req_ready === 1'b1) begin
        t_acc = cyc;
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (t_acc < 0) begin
      n_errors++;
      $display("FAIL %s_accept: request for div=%0d not accepted, expected accept", nm, sel);
    end else begin
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (t_acc >= 0) begin
      n_checks++;
      if (locked !== 1'b0 || err_timeout !== 1'b0) begin
        n_errors++;
        $display("FAIL %s_accept_clear: locked=%0b err_timeout=%0b, expected 0 and 0", nm, locked,
                 err_timeout);
      end
    end
  endtask

  task automatic check_hold(input logic [1:0] sel, input int t_acc, input string nm, output int r);
    int bad;
    bad = 0;
    for (int i = 1; i <= HOLD; i++) begin
      if (div_reset !== 1'b1 || div !== sel || req_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    r = t_acc + HOLD + 1;
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL %s_hold: %0d of %0d hold cycles wrong, expected 0", nm, bad, HOLD);
    end
    n_checks++;
    if (div_reset !== 1'b0 || div !== sel) begin
      n_errors++;
      $display("FAIL %s_release: div_reset=%0b div=%0d, expected 0 and %0d", nm, div_reset, div,
               sel);
    end
  endtask

  task automatic wait_outcome(input string nm, output int t_evt, output bit got_done);
    t_evt    = -1;
    got_done = 1'b0;
    for (int k = 0; k < TMO + 50; k++) begin
      if (done_pulse === 1'b1 || err_timeout === 1'b1) begin
        t_evt    = cyc;
        got_done = (done_pulse === 1'b1);
        break;
      end
      @(negedge clk);
    end
    n_checks++;
    if (t_evt < 0) begin
      n_errors++;
      $display("FAIL %s_outcome: neither done_pulse nor err_timeout seen, expected one", nm);
    end
  endtask

  task automatic switch_to(input logic [1:0] sel, input string nm);
    int t_acc, r, t_evt, lo;
    bit got_done;
    request(sel, nm, t_acc);
    if (t_acc < 0) return;
    check_hold(sel, t_acc, nm, r);
    wait_outcome(nm, t_evt, got_done);
    lo = r + half_period(sel) * (2 * EDGES - 1);
    n_checks++;
    if (!got_done || t_evt < lo || t_evt > lo + 10) begin
      n_errors++;
      $display("FAIL %s_done: done=%0b at %0d cycles after release, expected done at %0d..%0d", nm,
               got_done, t_evt - r, lo - r, lo - r + 10);
    end
    n_checks++;
    if (locked !== 1'b1 || div !== sel || req_ready !== 1'b1 || err_timeout !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_lock_state: locked=%0b div=%0d req_ready=%0b err=%0b, expected 1 %0d 1 0",
               nm, locked, div, req_ready, err_timeout, sel);
    end
    @(negedge clk);
    n_checks++;
    if (done_pulse !== 1'b0 || locked !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_pulse_width: done_pulse=%0b locked=%0b, expected 0 and 1", nm, done_pulse,
               locked);
    end
  endtask

  task automatic check_reset_values(input string nm);
    n_checks++;
    if (div !== 2'b00 || div_reset !== 1'b1 || locked !== 1'b0 || done_pulse !== 1'b0 ||
        err_timeout !== 1'b0 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL %s: div=%0d div_reset=%0b locked=%0b done=%0b err=%0b ready=%0b, expected 0 1 0 0 0 1",
               nm, div, div_reset, locked, done_pulse, err_timeout, req_ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_values");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (div_reset !== 1'b1 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_idle: div_reset=%0b req_ready=%0b, expected 1 and 1", div_reset,
               req_ready);
    end
  endtask

  task automatic test_first_request();
    switch_to(2'b11, "first");
  endtask

  task automatic test_back_to_back();
    switch_to(2'b10, "b2b_10");
    switch_to(2'b11, "b2b_11");
  endtask

  task automatic test_busy_request();
    int t_acc, r, t_acc2, r2, highs;
    request(2'b11, "busy_first", t_acc);
    if (t_acc < 0) return;
    check_hold(2'b11, t_acc, "busy_first", r);
    repeat (100) @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_ready: req_ready=%0b during settle, expected 0", req_ready);
    end
    request(2'b01, "busy_second", t_acc2);
    if (t_acc2 < 0) return;
    n_checks++;
    if (t_acc2 - r < 3 * half_period(2'b11) || t_acc2 - r > 3 * half_period(2'b11) + 10) begin
      n_errors++;
      $display("FAIL busy_accept_time: accepted %0d cycles after release, expected %0d..%0d",
               t_acc2 - r, 3 * half_period(2'b11), 3 * half_period(2'b11) + 10);
    end
    check_hold(2'b01, t_acc2, "busy_second", r2);
    highs = 0;
    for (int i = 0; i < 50; i++) begin
      if (div_reset !== 1'b0 || div !== 2'b01) highs++;
      @(negedge clk);
    end
    n_checks++;
    if (highs != 0) begin
      n_errors++;
      $display("FAIL busy_single_hold: %0d extra hold cycles after release, expected 0", highs);
    end
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_values("busy_reset");
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_hold();
    int t_acc;
    request(2'b10, "mid_hold", t_acc);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_reset_values("mid_hold_reset");
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_settle_timeout();
    int t_acc, r, t_evt;
    bit got_done;
    mode = DIV_LOW;
    request(2'b11, "settle_to", t_acc);
    if (t_acc >= 0) begin
      check_hold(2'b11, t_acc, "settle_to", r);
      wait_outcome("settle_to", t_evt, got_done);
      n_checks++;
      if (got_done || t_evt != r + TMO) begin
        n_errors++;
        $display("FAIL settle_to_time: done=%0b err at %0d cycles into settle, expected done=0 at %0d",
                 got_done, t_evt - r, TMO);
      end
      n_checks++;
      if (locked !== 1'b0 || req_ready !== 1'b1 || div_reset !== 1'b0 || err_timeout !== 1'b1) begin
        n_errors++;
        $display("FAIL settle_to_state: locked=%0b ready=%0b div_reset=%0b err=%0b, expected 0 1 0 1",
                 locked, req_ready, div_reset, err_timeout);
      end
      repeat (5) @(negedge clk);
      n_checks++;
      if (err_timeout !== 1'b1 || done_pulse !== 1'b0) begin
        n_errors++;
        $display("FAIL settle_to_sticky: err=%0b done=%0b, expected 1 and 0", err_timeout,
                 done_pulse);
      end
    end
    mode = DIV_RUN;
  endtask

  task automatic test_watchdog();
    int   t_err;
    logic was_locked;
    switch_to(2'b11, "wd_lock");
    repeat ($urandom_range(0, 600)) @(negedge clk);
    mode       = DIV_FREEZE;
    t_err      = -1;
    was_locked = 1'b0;
    for (int k = 0; k < 2 * TMO; k++) begin
      if (err_timeout === 1'b1) begin
        t_err = cyc;
        break;
      end
      was_locked = locked;
      @(negedge clk);
    end
    n_checks++;
    if (t_err < 0 || t_err - last_rise < TMO || t_err - last_rise > TMO + 1) begin
      n_errors++;
      $display("FAIL wd_time: err_timeout %0d cycles after last rise, expected %0d..%0d",
               t_err - last_rise, TMO, TMO + 1);
    end
    n_checks++;
    if (locked !== 1'b0 || was_locked !== 1'b1) begin
      n_errors++;
      $display("FAIL wd_locked: locked=%0b (before=%0b), expected 0 (before=1)", locked,
               was_locked);
    end
    mode = DIV_RUN;
    switch_to(2'b11, "wd_recover");
  endtask

  task automatic test_random();
    logic [1:0] sel;
    int         t_acc, d;
    logic       exp_rst;
    string      nm;
    for (int it = 0; it < 6; it++) begin
      nm  = $sformatf("rand%0d", it);
      sel = 2'($urandom_range(0, 3));
      repeat ($urandom_range(0, 15)) @(negedge clk);
      if (sel == 2'b11 && $urandom_range(0, 2) != 0) begin
        switch_to(sel, nm);
      end else begin
        request(sel, nm, t_acc);
        d = $urandom_range(0, HOLD + 30);
        repeat (d) @(negedge clk);
        exp_rst = (d + 1 <= HOLD);
        n_checks++;
        if (div_reset !== exp_rst || div !== sel) begin
          n_errors++;
          $display("FAIL %s_abort_state: div_reset=%0b div=%0d at %0d cycles after accept, expected %0b %0d",
                   nm, div_reset, div, d + 1, exp_rst, sel);
        end
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_values({nm, "_reset"});
        reset_n = 1'b1;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_request();
    test_back_to_back();
    test_busy_request();
    test_reset_mid_hold();
    test_settle_timeout();
    test_watchdog();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
